// File: rtl/fx2fp_arbiter_if.sv
// Signal bundle between fx2fp_arbiter, its requesters, the shared converter and the response consumer.
interface fx2fp_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int INT_WID   = 16,
    parameter int FRA_WID   = 16,
    parameter int FLOAT_WID = 32,
    parameter int PIPE_LAT  = 5
);
    localparam int ID_WID  = $clog2(NUM_REQ);
    localparam int CNT_WID = $clog2(PIPE_LAT + 2);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*INT_WID-1:0] req_fixed_integer;
    logic [NUM_REQ*FRA_WID-1:0] req_fixed_fraction;
    logic                       flush_req;
    logic                       flush_done;
    logic                       cvt_clk_en;
    logic [INT_WID-1:0]         cvt_fixed_integer;
    logic [FRA_WID-1:0]         cvt_fixed_fraction;
    logic [FLOAT_WID-1:0]       cvt_float_val;
    logic                       rsp_valid;
    logic [ID_WID-1:0]          rsp_id;
    logic [FLOAT_WID-1:0]       rsp_float;
    logic [CNT_WID-1:0]         in_flight;
    logic                       busy;

    modport slave (
        input  req_valid, req_fixed_integer, req_fixed_fraction, flush_req, cvt_float_val,
        output req_ready, flush_done, cvt_clk_en, cvt_fixed_integer, cvt_fixed_fraction,
               rsp_valid, rsp_id, rsp_float, in_flight, busy
    );

    modport master (
        output req_valid, req_fixed_integer, req_fixed_fraction, flush_req, cvt_float_val,
        input  req_ready, flush_done, cvt_clk_en, cvt_fixed_integer, cvt_fixed_fraction,
               rsp_valid, rsp_id, rsp_float, in_flight, busy
    );
endinterface

// File: rtl/fx2fp_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-to-float converter among NUM_REQ requesters,
// with an id tag pipeline that returns each result to its owner in acceptance order.
module fx2fp_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int INT_WID   = 16,
    parameter int FRA_WID   = 16,
    parameter int FLOAT_WID = 32,
    parameter int PIPE_LAT  = 5
) (
    input logic            clk,
    input logic            rstn,
    fx2fp_arbiter_if.slave bus
);
    localparam int ID_WID  = $clog2(NUM_REQ);
    localparam int CNT_WID = $clog2(PIPE_LAT + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [ID_WID-1:0]    r_rrPtr;
    logic [PIPE_LAT-1:0]  r_tagValid;
    logic [ID_WID-1:0]    r_tagId [PIPE_LAT];
    logic [CNT_WID-1:0]   r_inFlight;
    logic                 r_rspValid;
    logic [ID_WID-1:0]    r_rspId;
    logic [FLOAT_WID-1:0] r_rspFloat;
    logic                 r_flushDone;
    logic                 r_flushAck;

    logic                 w_cvtEn;
    logic                 w_anyValid;
    logic                 w_arbEn;
    logic                 w_grant;
    logic [ID_WID-1:0]    w_grantIdx;
    logic [ID_WID-1:0]    w_rrNext;
    logic [ID_WID:0]      w_scan;
    logic [NUM_REQ-1:0]   w_ready;
    logic [INT_WID-1:0]   w_cvtInt;
    logic [FRA_WID-1:0]   w_cvtFra;
    logic                 w_flushPulse;
    logic                 w_ackSet;
    logic                 w_rspSet;

    assign w_cvtEn    = (r_state != IDLE);
    assign w_anyValid = |bus.req_valid;
    assign w_arbEn    = (r_state == RUN) && !bus.flush_req;
    assign w_rspSet   = w_cvtEn && r_tagValid[PIPE_LAT-1];

    // Cyclic search starting at the round-robin pointer; first valid requester wins.
    always_comb begin
        w_grant    = 1'b0;
        w_grantIdx = '0;
        w_scan     = '0;
        if (w_arbEn) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = {1'b0, r_rrPtr} + (ID_WID+1)'(k);
                if (w_scan >= (ID_WID+1)'(NUM_REQ)) begin
                    w_scan = w_scan - (ID_WID+1)'(NUM_REQ);
                end
                if (!w_grant && bus.req_valid[w_scan[ID_WID-1:0]]) begin
                    w_grant    = 1'b1;
                    w_grantIdx = w_scan[ID_WID-1:0];
                end
            end
        end
    end

    always_comb begin
        w_ready  = '0;
        w_cvtInt = '0;
        w_cvtFra = '0;
        if (w_grant) begin
            w_ready[w_grantIdx] = 1'b1;
            w_cvtInt = bus.req_fixed_integer[w_grantIdx*INT_WID +: INT_WID];
            w_cvtFra = bus.req_fixed_fraction[w_grantIdx*FRA_WID +: FRA_WID];
        end
    end

    assign w_rrNext = (w_grantIdx == ID_WID'(NUM_REQ - 1)) ? '0 : w_grantIdx + ID_WID'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The flush acknowledge keeps a held flush_req from producing more than one flush_done.
    always_comb begin
        w_nextState  = r_state;
        w_flushPulse = 1'b0;
        w_ackSet     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.flush_req) begin
                    if (!r_flushAck) begin
                        w_flushPulse = 1'b1;
                        w_ackSet     = 1'b1;
                    end
                end else if (w_anyValid) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (bus.flush_req) begin
                    w_nextState = DRAIN;
                    w_ackSet    = 1'b1;
                end else if (!w_anyValid && (r_inFlight == '0)) begin
                    w_nextState = IDLE;
                end
            end
            DRAIN: begin
                if (r_inFlight == '0) begin
                    w_nextState  = IDLE;
                    w_flushPulse = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rrPtr     <= '0;
            r_flushAck  <= 1'b0;
            r_flushDone <= 1'b0;
            r_inFlight  <= '0;
        end else begin
            r_flushAck  <= bus.flush_req && (r_flushAck || w_ackSet);
            r_flushDone <= w_flushPulse;
            if (w_grant) begin
                r_rrPtr <= w_rrNext;
            end
            case ({w_grant, w_rspSet})
                2'b10:   r_inFlight <= r_inFlight + CNT_WID'(1);
                2'b01:   r_inFlight <= r_inFlight - CNT_WID'(1);
                default: r_inFlight <= r_inFlight;
            endcase
        end
    end

    // Tags advance in lockstep with the converter stages so the last tag lines up with cvt_float_val.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tagValid <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_tagId[k] <= '0;
            end
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspFloat <= '0;
        end else if (w_cvtEn) begin
            r_tagValid[0] <= w_grant;
            r_tagId[0]    <= w_grantIdx;
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_tagValid[k] <= r_tagValid[k-1];
                r_tagId[k]    <= r_tagId[k-1];
            end
            r_rspValid <= r_tagValid[PIPE_LAT-1];
            r_rspId    <= r_tagId[PIPE_LAT-1];
            r_rspFloat <= bus.cvt_float_val;
        end else begin
            r_rspValid <= 1'b0;
        end
    end

    assign bus.req_ready          = w_ready;
    assign bus.cvt_clk_en         = w_cvtEn;
    assign bus.cvt_fixed_integer  = w_cvtInt;
    assign bus.cvt_fixed_fraction = w_cvtFra;
    assign bus.flush_done         = r_flushDone;
    assign bus.rsp_valid          = r_rspValid;
    assign bus.rsp_id             = r_rspId;
    assign bus.rsp_float          = r_rspFloat;
    assign bus.in_flight          = r_inFlight;
    assign bus.busy               = (r_state != IDLE);
endmodule

// File: tb/tb_fx2fp_arbiter.sv
// Bench for fx2fp_arbiter: a behavioural converter plus a queue-based scoreboard of expected results.
module tb_fx2fp_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int INT_WID   = 16;
    localparam int FRA_WID   = 16;
    localparam int FLOAT_WID = 32;
    localparam int PIPE_LAT  = 5;
    localparam int ID_WID    = $clog2(NUM_REQ);
    localparam int CNT_WID   = $clog2(PIPE_LAT + 2);
    localparam int CTL_W     = NUM_REQ + 4 + CNT_WID + INT_WID + FRA_WID;

    typedef struct {
        int                   id;
        logic [FLOAT_WID-1:0] f;
        int                   due;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn;

    fx2fp_arbiter_if #(.NUM_REQ(NUM_REQ), .INT_WID(INT_WID), .FRA_WID(FRA_WID),
                       .FLOAT_WID(FLOAT_WID), .PIPE_LAT(PIPE_LAT)) bus ();

    fx2fp_arbiter #(.NUM_REQ(NUM_REQ), .INT_WID(INT_WID), .FRA_WID(FRA_WID),
                    .FLOAT_WID(FLOAT_WID), .PIPE_LAT(PIPE_LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nBad = 0;
    int cyc  = 0;

    int   mState;
    int   mRr;
    bit   mAck;
    bit   mFd;
    rsp_t expQ[$];

    logic [INT_WID-1:0]   dInt [NUM_REQ];
    logic [FRA_WID-1:0]   dFra [NUM_REQ];
    logic [FLOAT_WID-1:0] cvtPipe [PIPE_LAT];

    logic [CTL_W-1:0]     obsCtl, expCtl;
    logic [NUM_REQ-1:0]   obsReady;
    logic                 obsRv, expRv, obsBusy, obsFd;
    logic [ID_WID-1:0]    obsId, expId;
    logic [FLOAT_WID-1:0] obsF, expF;

    // Truncating signed fixed-point to IEEE single conversion.
    function automatic logic [31:0] fx2f(input logic [INT_WID-1:0] ip, input logic [FRA_WID-1:0] fp);
        longint     v;
        int         p;
        logic [31:0] m;
        logic       s;
        v = longint'($signed({ip, fp}));
        if (v == 0) return 32'h0;
        s = (v < 0);
        if (s) v = -v;
        p = 0;
        for (int b = 0; b < 40; b++) if (v[b]) p = b;
        if (p >= 23) m = 32'(v >> (p - 23));
        else m = 32'(v << (23 - p));
        return {s, 8'(p - FRA_WID + 127), m[22:0]};
    endfunction

    always @(posedge clk) begin
        if (bus.cvt_clk_en) begin
            cvtPipe[0] <= fx2f(bus.cvt_fixed_integer, bus.cvt_fixed_fraction);
            for (int k = 1; k < PIPE_LAT; k++) cvtPipe[k] <= cvtPipe[k-1];
        end
    end
    assign bus.cvt_float_val = cvtPipe[PIPE_LAT-1];

    task automatic setData(input int i, input logic [INT_WID-1:0] iv, input logic [FRA_WID-1:0] fv);
        dInt[i] = iv;
        dFra[i] = fv;
        bus.req_fixed_integer[i*INT_WID +: INT_WID]  = iv;
        bus.req_fixed_fraction[i*FRA_WID +: FRA_WID] = fv;
    endtask

    task automatic resetModel();
        mState = 0;
        mRr    = 0;
        mAck   = 0;
        mFd    = 0;
        expQ.delete();
    endtask

    task automatic resetDut();
        bus.req_valid = '0;
        bus.flush_req = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        resetModel();
    endtask

    // Predicts this cycle from the scoreboard, samples the DUT mid-cycle, then advances one clock.
    task automatic stepCycle();
        int                 g;
        int                 inf;
        int                 idx;
        bit                 nextFd;
        bit                 ackSet;
        logic [NUM_REQ-1:0] er;
        logic [INT_WID-1:0] ei;
        logic [FRA_WID-1:0] ef;
        g = -1; nextFd = 0; ackSet = 0; er = '0; ei = '0; ef = '0;
        if (mState == 1 && !bus.flush_req) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (mRr + k) % NUM_REQ;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            er[g] = 1'b1;
            ei = dInt[g];
            ef = dFra[g];
        end
        expRv = 1'b0; expId = '0; expF = '0;
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            expRv = 1'b1;
            expId = ID_WID'(expQ[0].id);
            expF  = expQ[0].f;
            void'(expQ.pop_front());
        end
        inf = expQ.size();
        expCtl = {er, 1'(mState != 0), 1'(mState != 0), CNT_WID'(inf), mFd, expRv, ei, ef};
        @(negedge clk);
        obsCtl   = {bus.req_ready, bus.busy, bus.cvt_clk_en, bus.in_flight, bus.flush_done,
                    bus.rsp_valid, bus.cvt_fixed_integer, bus.cvt_fixed_fraction};
        obsReady = bus.req_ready;
        obsRv    = bus.rsp_valid;
        obsId    = bus.rsp_id;
        obsF     = bus.rsp_float;
        obsBusy  = bus.busy;
        obsFd    = bus.flush_done;
        if (g >= 0) begin
            expQ.push_back('{g, fx2f(ei, ef), cyc + PIPE_LAT + 1});
            mRr = (g + 1) % NUM_REQ;
        end
        case (mState)
            0: if (bus.flush_req) begin
                   if (!mAck) begin nextFd = 1; ackSet = 1; end
               end else if (bus.req_valid != 0) mState = 1;
            1: if (bus.flush_req) begin mState = 2; ackSet = 1; end
               else if (bus.req_valid == 0 && inf == 0) mState = 0;
            default: if (inf == 0) begin mState = 0; nextFd = 1; end
        endcase
        mAck = bus.flush_req && (mAck || ackSet);
        mFd  = nextFd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.flush_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) setData(i, INT_WID'($urandom), FRA_WID'($urandom));
        rstn = 1'b0;
        #3;
        obsCtl = {bus.req_ready, bus.busy, bus.cvt_clk_en, bus.in_flight, bus.flush_done,
                  bus.rsp_valid, bus.cvt_fixed_integer, bus.cvt_fixed_fraction};
        nVec++;
        if (obsCtl !== '0) begin nBad++; $display("FAIL reset_ctl got=%h want=0", obsCtl); end
        nVec++;
        if ({bus.rsp_id, bus.rsp_float} !== '0) begin
            nBad++; $display("FAIL reset_rsp got id=%0d f=%h want 0/0", bus.rsp_id, bus.rsp_float);
        end
        bus.req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        resetModel();
    endtask

    task automatic test_single(input int req, input logic [INT_WID-1:0] iv,
                               input logic [FRA_WID-1:0] fv, input logic [31:0] want);
        int seen = 0;
        int accAt = -1;
        setData(req, iv, fv);
        bus.req_valid = '0;
        bus.req_valid[req] = 1'b1;
        for (int c = 0; c < PIPE_LAT + 6; c++) begin
            stepCycle();
            nVec++;
            if (obsCtl !== expCtl) begin nBad++; $display("FAIL single_ctl cyc=%0d got=%h want=%h", c, obsCtl, expCtl); end
            if (expRv) begin
                nVec++;
                if ({obsId, obsF} !== {expId, expF}) begin nBad++; $display("FAIL single_rsp got=%0d/%h want=%0d/%h", obsId, obsF, expId, expF); end
            end
            if (obsReady[req]) begin accAt = c; bus.req_valid = '0; end
            if (obsRv) begin
                seen++;
                nVec++;
                if ({obsId, obsF} !== {ID_WID'(req), want}) begin nBad++; $display("FAIL single_value got=%0d/%h want=%0d/%h", obsId, obsF, req, want); end
                nVec++;
                if (c != accAt + PIPE_LAT + 1) begin nBad++; $display("FAIL single_latency got=%0d want=%0d", c - accAt, PIPE_LAT + 1); end
            end
        end
        nVec++;
        if (seen != 1 || accAt != 1 || obsBusy !== 1'b0) begin
            nBad++; $display("FAIL single_count got rsp=%0d acc=%0d busy=%b want 1/1/0", seen, accAt, obsBusy);
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int rspIds[$];
        int firstRsp = -1;
        int lastRsp = -1;
        resetDut();
        for (int i = 0; i < NUM_REQ; i++) setData(i, INT_WID'($urandom), FRA_WID'($urandom));
        for (int c = 0; c < 13 + PIPE_LAT + 4; c++) begin
            bus.req_valid = (c < 13) ? '1 : '0;
            stepCycle();
            nVec++;
            if (obsCtl !== expCtl) begin nBad++; $display("FAIL rr_ctl cyc=%0d got=%h want=%h", c, obsCtl, expCtl); end
            if (expRv) begin
                nVec++;
                if ({obsId, obsF} !== {expId, expF}) begin nBad++; $display("FAIL rr_rsp got=%0d/%h want=%0d/%h", obsId, obsF, expId, expF); end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (obsReady[i]) begin
                    grants.push_back(i);
                    setData(i, INT_WID'($urandom), FRA_WID'($urandom));
                end
            end
            if (obsRv) begin
                rspIds.push_back(int'(obsId));
                if (firstRsp < 0) firstRsp = c;
                lastRsp = c;
            end
        end
        nVec++;
        if (grants.size() != 12 || rspIds.size() != 12 || lastRsp - firstRsp != 11) begin
            nBad++; $display("FAIL rr_counts got g=%0d r=%0d span=%0d want 12/12/11", grants.size(), rspIds.size(), lastRsp - firstRsp);
        end
        for (int j = 0; j < grants.size(); j++) begin
            nVec++;
            if (grants[j] != j % NUM_REQ) begin nBad++; $display("FAIL rr_order j=%0d got=%0d want=%0d", j, grants[j], j % NUM_REQ); end
        end
        for (int j = 0; j < rspIds.size(); j++) begin
            nVec++;
            if (rspIds[j] != j % NUM_REQ) begin nBad++; $display("FAIL rr_rsp_order j=%0d got=%0d want=%0d", j, rspIds[j], j % NUM_REQ); end
        end
    endtask

    task automatic test_flush();
        int nGrant = 0;
        int nRsp = 0;
        int nFd = 0;
        for (int c = 0; c < 34; c++) begin
            bus.req_valid = (c < 30) ? '1 : '0;
            bus.flush_req = (c >= 4 && c < 30);
            stepCycle();
            nVec++;
            if (obsCtl !== expCtl) begin nBad++; $display("FAIL flush_ctl cyc=%0d got=%h want=%h", c, obsCtl, expCtl); end
            if (expRv) begin
                nVec++;
                if ({obsId, obsF} !== {expId, expF}) begin nBad++; $display("FAIL flush_rsp got=%0d/%h want=%0d/%h", obsId, obsF, expId, expF); end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (obsReady[i]) begin nGrant++; setData(i, INT_WID'($urandom), FRA_WID'($urandom)); end
            end
            if (obsRv) nRsp++;
            if (obsFd) nFd++;
        end
        nVec++;
        if (nGrant != 3 || nRsp != 3 || nFd != 1 || obsBusy !== 1'b0 || bus.in_flight !== '0) begin
            nBad++; $display("FAIL flush_summary got g=%0d r=%0d fd=%0d busy=%b inf=%0d want 3/3/1/0/0", nGrant, nRsp, nFd, obsBusy, bus.in_flight);
        end
    endtask

    task automatic test_reset_mid();
        int nRsp = 0;
        bus.req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            nVec++;
            if (obsCtl !== expCtl) begin nBad++; $display("FAIL rmid_ctl cyc=%0d got=%h want=%h", c, obsCtl, expCtl); end
            for (int i = 0; i < NUM_REQ; i++) if (obsReady[i]) setData(i, INT_WID'($urandom), FRA_WID'($urandom));
        end
        nVec++;
        if (bus.in_flight !== CNT_WID'(4)) begin nBad++; $display("FAIL rmid_pre got inflight=%0d want 4", bus.in_flight); end
        #2 rstn = 1'b0;
        #1;
        obsCtl = {bus.req_ready, bus.busy, bus.cvt_clk_en, bus.in_flight, bus.flush_done,
                  bus.rsp_valid, bus.cvt_fixed_integer, bus.cvt_fixed_fraction};
        nVec++;
        if (obsCtl !== '0 || {bus.rsp_id, bus.rsp_float} !== '0) begin
            nBad++; $display("FAIL rmid_async got ctl=%h id=%0d f=%h want all 0", obsCtl, bus.rsp_id, bus.rsp_float);
        end
        bus.req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        resetModel();
        for (int c = 0; c < 10; c++) begin
            stepCycle();
            nVec++;
            if (obsCtl !== expCtl) begin nBad++; $display("FAIL rmid_after cyc=%0d got=%h want=%h", c, obsCtl, expCtl); end
            if (obsRv) nRsp++;
        end
        nVec++;
        if (nRsp != 0) begin nBad++; $display("FAIL rmid_rsp got=%0d want=0", nRsp); end
    endtask

    task automatic test_alternating();
        bit pend = 0;
        int gap = 0;
        int burst = 0;
        int nIdle = 0;
        bit prevBusy = 0;
        for (int c = 0; c < 90; c++) begin
            if (!pend && gap == 0) begin
                pend = 1;
                setData(1, INT_WID'($urandom), FRA_WID'($urandom));
            end
            bus.req_valid = pend ? NUM_REQ'(2) : '0;
            stepCycle();
            nVec++;
            if (obsCtl !== expCtl) begin nBad++; $display("FAIL alt_ctl cyc=%0d got=%h want=%h", c, obsCtl, expCtl); end
            if (expRv) begin
                nVec++;
                if ({obsId, obsF} !== {expId, expF}) begin nBad++; $display("FAIL alt_rsp got=%0d/%h want=%0d/%h", obsId, obsF, expId, expF); end
            end
            if (prevBusy && !obsBusy) nIdle++;
            prevBusy = obsBusy;
            if (pend && obsReady[1]) begin
                pend = 0;
                burst++;
                gap = burst[0] ? $urandom_range(0, 2) : PIPE_LAT + 3;
            end else if (!pend && gap > 0) gap--;
        end
        nVec++;
        if (nIdle < 2) begin nBad++; $display("FAIL alt_idle got=%0d want>=2", nIdle); end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend = '0;
        int flushCnt = 0;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pend[i] && $urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        setData(i, INT_WID'($urandom), FRA_WID'($urandom));
                    end
                end
                if (flushCnt > 0) flushCnt--;
                else if ($urandom_range(0, 39) == 0) flushCnt = $urandom_range(1, 6);
            end else begin
                pend = '0;
                flushCnt = 0;
            end
            bus.req_valid = pend;
            bus.flush_req = (flushCnt > 0);
            stepCycle();
            nVec++;
            if (obsCtl !== expCtl) begin nBad++; $display("FAIL rand_ctl cyc=%0d got=%h want=%h", c, obsCtl, expCtl); end
            if (expRv) begin
                nVec++;
                if ({obsId, obsF} !== {expId, expF}) begin nBad++; $display("FAIL rand_rsp got=%0d/%h want=%0d/%h", obsId, obsF, expId, expF); end
            end
            pend = pend & ~obsReady;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstn = 1'b0;
        bus.req_valid = '0;
        bus.flush_req = 1'b0;
        bus.req_fixed_integer = '0;
        bus.req_fixed_fraction = '0;
        for (int i = 0; i < NUM_REQ; i++) begin dInt[i] = '0; dFra[i] = '0; end
        resetModel();
        test_reset();
        test_single(2, INT_WID'(3), FRA_WID'(0), 32'h40400000);
        test_single(0, {INT_WID{1'b1}}, FRA_WID'(16'h8000), 32'hBF000000);
        test_round_robin();
        test_flush();
        test_reset_mid();
        test_alternating();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
